muldiv_compute_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle compute stage. It sits in the C stage beside the ALU and executes RISC-V M-extension multiply/divide ops iteratively. It contains a generalised N-source forwarding mux on both operands. It stalls the front of the pipeline through a Stall_C output until its result is available for the CM pipeline registers.

---
 rtl/muldiv_compute_unit_if.sv | 35 +++
 rtl/muldiv_compute_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_compute_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_compute_unit_if.sv
// C-stage multiply/divide request and result bundle.
// master = pipeline side, slave = muldiv_compute_unit.
interface muldiv_compute_unit_if #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
);
    localparam int FSELW = $clog2(FWD_SRCS + 1);

    logic                     ValidInstruction_C;
    logic                     MulDivEn_C;
    logic [2:0]               MulDivOp_C;
    logic [XLEN-1:0]          OperandA_C;
    logic [XLEN-1:0]          OperandB_C;
    logic [FSELW-1:0]         FwdSelA_C;
    logic [FSELW-1:0]         FwdSelB_C;
    logic [FWD_SRCS*XLEN-1:0] ForwardData;
    logic                     Flush_C;
    logic                     Stall_C;
    logic [XLEN-1:0]          MulDivResult_C;
    logic                     MulDivResultValid_C;

    modport master (
        output ValidInstruction_C, MulDivEn_C, MulDivOp_C,
        output OperandA_C, OperandB_C, FwdSelA_C, FwdSelB_C,
        output ForwardData, Flush_C,
        input  Stall_C, MulDivResult_C, MulDivResultValid_C
    );

    modport slave (
        input  ValidInstruction_C, MulDivEn_C, MulDivOp_C,
        input  OperandA_C, OperandB_C, FwdSelA_C, FwdSelB_C,
        input  ForwardData, Flush_C,
        output Stall_C, MulDivResult_C, MulDivResultValid_C
    );
endinterface

// File: rtl/muldiv_compute_unit.sv
// Iterative RV M-extension unit for the C stage with operand forwarding.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier runs out.
module muldiv_compute_unit #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_compute_unit_if.slave bus
);
    localparam int FSELW = $clog2(FWD_SRCS + 1);
    localparam int CW    = $clog2(XLEN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op;
    logic              neg;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   result;

    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [2:0]        op_in;
    logic              start;
    logic              is_div;
    logic              signed_a;
    logic              signed_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_in;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   exc_result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_busy;
    logic              finish;
`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0]     sh;
    logic [XLEN-2:0]   rest_mask;
    logic              rest_zero;
`endif

    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [FSELW-1:0]         sel,
        input logic [XLEN-1:0]          opnd,
        input logic [FWD_SRCS*XLEN-1:0] data
    );
        logic [XLEN-1:0] v;
        v = 'x;
        if (sel == '0)
            v = opnd;
        for (int k = 1; k <= FWD_SRCS; k++)
            if (sel == FSELW'(k))
                v = data[(k-1)*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic [XLEN-1:0] finalize(
        input logic [2*XLEN-1:0] a,
        input logic [2:0]        o,
        input logic              n
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = n ? -a : a;
        q = n ? -a[XLEN-1:0] : a[XLEN-1:0];
        r = n ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        if (!o[2])
            return (o[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        return o[1] ? r : q;
    endfunction

    assign op_in = bus.MulDivOp_C;
    assign start = bus.ValidInstruction_C & bus.MulDivEn_C
                 & ~bus.Flush_C & (state == IDLE);

    assign bus.Stall_C = start | ((state == BUSY) & ~bus.Flush_C);
    assign bus.MulDivResultValid_C = (state == DONE) & ~bus.Flush_C;
    assign bus.MulDivResult_C = result;

    // Operand forwarding and request decode: magnitudes, result sign, exceptions.
    always_comb begin
        src_a    = fwd_pick(bus.FwdSelA_C, bus.OperandA_C, bus.ForwardData);
        src_b    = fwd_pick(bus.FwdSelB_C, bus.OperandB_C, bus.ForwardData);
        is_div   = op_in[2];
        signed_a = (op_in == 3'd1) | (op_in == 3'd2)
                 | (op_in == 3'd4) | (op_in == 3'd6);
        signed_b = (op_in == 3'd1) | (op_in == 3'd4) | (op_in == 3'd6);
        a_neg    = signed_a & src_a[XLEN-1];
        b_neg    = signed_b & src_b[XLEN-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        neg_in   = (is_div & op_in[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div & (src_b == '0);
        div_ovf  = is_div & ~op_in[0] & (src_a == MOST_NEG) & (src_b == '1);
        exc_result = '0;
        if (div_zero)
            exc_result = op_in[1] ? src_a : '1;
        else if (div_ovf)
            exc_result = op_in[1] ? '0 : src_a;
    end

    // One radix-2 shift-add or restoring-divide step on the shared accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_next  = div_diff[XLEN]
                  ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`ifdef MULDIV_EARLY_OUT_EN
        sh        = CW'(XLEN) - cnt;
        rest_mask = {(XLEN-1){1'b1}} >> sh;
        rest_zero = ~op[2] & ((acc[XLEN-1:1] & rest_mask) == '0);
        acc_busy  = rest_zero ? (mul_next >> (cnt - CW'(1)))
                  : (op[2] ? div_next : mul_next);
        finish    = rest_zero | (cnt == CW'(1));
`else
        acc_busy  = op[2] ? div_next : mul_next;
        finish    = (cnt == CW'(1));
`endif
    end

    // Sequencer: accept in IDLE, iterate in BUSY, present the result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op  <= op_in;
                        neg <= neg_in;
                        if (div_zero | div_ovf) begin
                            result <= exc_result;
                            state  <= DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            opb   <= is_div ? mag_b : mag_a;
                            cnt   <= CW'(XLEN);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.Flush_C) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_busy;
                        cnt <= cnt - CW'(1);
                        if (finish) begin
                            result <= finalize(acc_busy, op, neg);
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_compute_unit.sv
// Scoreboard bench for muldiv_compute_unit: reference model, latency,
// stall, forwarding, flush and reset behaviour.
module tb_muldiv_compute_unit;
    localparam int XLEN     = 32;
    localparam int FWD_SRCS = 2;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    muldiv_compute_unit_if #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) bus_if ();

    muldiv_compute_unit #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] m;
        int          h;
        if (op[2] && (b == 0))
            return 1;
        if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
            return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2]) begin
            m = (op == 3'd1 && b[31]) ? -b : b;
            h = -1;
            for (int i = 0; i < 32; i++)
                if (m[i]) h = i;
            return (h < 0) ? 2 : h + 2;
        end
`else
        m = a;
        h = 0;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        bus_if.ValidInstruction_C = 1'b0;
        bus_if.MulDivEn_C         = 1'b0;
        bus_if.Flush_C            = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] sela,
                         input logic [1:0] selb, input logic [63:0] fwd,
                         input bit push);
        logic [31:0] ea;
        logic [31:0] eb;
        exp_t        e;
        ea = (sela == 0) ? a : (sela == 1) ? fwd[31:0] : fwd[63:32];
        eb = (selb == 0) ? b : (selb == 1) ? fwd[31:0] : fwd[63:32];
        bus_if.MulDivOp_C         = op;
        bus_if.OperandA_C         = a;
        bus_if.OperandB_C         = b;
        bus_if.FwdSelA_C          = sela;
        bus_if.FwdSelB_C          = selb;
        bus_if.ForwardData        = fwd;
        bus_if.ValidInstruction_C = 1'b1;
        bus_if.MulDivEn_C         = 1'b1;
        if (push) begin
            e.res = ref_op(op, ea, eb);
            e.lat = ref_lat(op, ea, eb);
            sb_q.push_back(e);
        end
        @(negedge clk);
        check("stall_at_start", bus_if.Stall_C, 1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   lat;
        int   stall_cnt;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        lat = 0;
        stall_cnt = 1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus_if.MulDivResultValid_C) begin
                lat = i;
                break;
            end
            if (bus_if.Stall_C)
                stall_cnt++;
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_stall_cycles"}, stall_cnt, e.lat);
        check({tag, "_stall_done"}, bus_if.Stall_C, 0);
        check({tag, "_result"}, bus_if.MulDivResult_C, e.res);
        @(negedge clk);
        check({tag, "_pulse"}, bus_if.MulDivResultValid_C, 0);
        check({tag, "_hold"}, bus_if.MulDivResult_C, e.res);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 2'd0, 2'd0, $urandom, 1'b1);
        wait_result(tag);
    endtask

    initial begin
        int          seen;
        logic [63:0] fwd;
        reset = 1'b1;
        idle_inputs();
        bus_if.MulDivOp_C  = '0;
        bus_if.OperandA_C  = '0;
        bus_if.OperandB_C  = '0;
        bus_if.FwdSelA_C   = '0;
        bus_if.FwdSelB_C   = '0;
        bus_if.ForwardData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", bus_if.Stall_C, 0);
        check("rst_valid", bus_if.MulDivResultValid_C, 0);
        check("rst_result", bus_if.MulDivResult_C, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("mul_7x6", 3'd0, 32'd7, 32'd6);
        run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000);
        run("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'd2);
        run("div_m7", 3'd4, -32'sd7, 32'd2);
        run("rem_m7", 3'd6, -32'sd7, 32'd2);
        run("divu_zero", 3'd5, 32'd7, 32'd0);
        run("rem_zero", 3'd6, 32'd5, 32'd0);
        run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run("mul_5x1", 3'd0, 32'd5, 32'd1);

        fwd = {32'd100, 32'd3};
        issue(3'd5, 32'd1, 32'd1, 2'd2, 2'd1, fwd, 1'b1);
        wait_result("fwd_divu");

        for (int n = 0; n < 24; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                  {pick(), pick()}, 1'b1);
            wait_result("rand");
        end

        bus_if.MulDivEn_C = 1'b1;
        bus_if.MulDivOp_C = 3'd4;
        bus_if.OperandB_C = 32'd0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.Stall_C || bus_if.MulDivResultValid_C) seen++;
        end
        check("invalid_ignored", seen, 0);
        @(posedge clk);
        #1;
        idle_inputs();

        bus_if.ValidInstruction_C = 1'b1;
        bus_if.MulDivEn_C         = 1'b1;
        bus_if.Flush_C            = 1'b1;
        @(negedge clk);
        check("flush_start_stall", bus_if.Stall_C, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.Stall_C || bus_if.MulDivResultValid_C) seen++;
        end
        check("flush_start_none", seen, 0);
        @(posedge clk);
        #1;

        issue(3'd4, 32'd1000, 32'd7, 2'd0, 2'd0, 64'd0, 1'b0);
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus_if.MulDivResultValid_C) seen++;
            @(posedge clk);
            #1;
        end
        bus_if.Flush_C = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", bus_if.Stall_C, 0);
        check("flush_busy_valid", seen + int'(bus_if.MulDivResultValid_C), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        issue(3'd5, 32'd1000, 32'd7, 2'd0, 2'd0, 64'd0, 1'b1);
        wait_result("after_flush");

        issue(3'd0, 32'd9, 32'd9, 2'd0, 2'd0, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stall", bus_if.Stall_C, 0);
        check("midrst_valid", bus_if.MulDivResultValid_C, 0);
        check("midrst_result", bus_if.MulDivResult_C, 0);
        @(posedge clk);
        #1;
        run("after_reset", 3'd7, 32'd29, 32'd6);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
